// File: rtl/tx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_ctrl_pkg                                                                |
// | State encoding and default timing for the differential TX sequencer.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package tx_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_DETECT = 3'd1;
    localparam state_t S_SETTLE = 3'd2;
    localparam state_t S_ACTIVE = 3'd3;
    localparam state_t S_DRAIN  = 3'd4;

    localparam int c_DET_CICLOS    = 16;
    localparam int c_SETTLE_CICLOS = 4;
    localparam int c_DRAIN_CICLOS  = 8;
    localparam int c_CNT_W         = 8;

endpackage
`default_nettype wire

// File: rtl/contador_ciclos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | contador_ciclos                                                            |
// | Loadable down-counter that parks at zero and flags it.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module contador_ciclos #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/controlador_tx_diferencial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | controlador_tx_diferencial                                                 |
// | Sequences receiver detect, electrical-idle exit/entry and the NRZI emitter.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module controlador_tx_diferencial
    import tx_ctrl_pkg::*;
#(
    parameter int DET_CICLOS    = c_DET_CICLOS,
    parameter int SETTLE_CICLOS = c_SETTLE_CICLOS,
    parameter int DRAIN_CICLOS  = c_DRAIN_CICLOS,
    parameter int CNT_W         = c_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic det_req,
    input  logic tx_req,
    input  logic idle_req,
    input  logic rx_presente,
    input  logic cfg_margin,
    input  logic cfg_swing,
    input  logic cfg_deemph,
    output logic enb_emisor,
    output logic rst_emisor,
    output logic TxElecIdle,
    output logic TxDetectRx,
    output logic TxMargin,
    output logic TxSwing,
    output logic TxDeemph,
    output logic det_ok,
    output logic listo,
    output logic ocupado
);

    localparam logic [CNT_W-1:0] c_DET_LOAD    = CNT_W'(DET_CICLOS - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE_CICLOS - 1);
    localparam logic [CNT_W-1:0] c_DRAIN_LOAD  = CNT_W'(DRAIN_CICLOS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_zero;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_stop;

    logic w_elec_idle, w_rst_emisor, w_enb, w_detect, w_listo;
    logic r_elec_idle, r_rst_emisor, r_enb, r_detect, r_listo, r_ocupado;
    logic r_margin, r_swing, r_deemph, r_det_ok;

    // idle_req overrides tx_req wherever both matter
    assign w_stop = !tx_req || idle_req;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (det_req) begin
                    w_state_nxt = S_DETECT;
                end else if (!w_stop && r_det_ok) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_DETECT: begin
                if (w_zero) w_state_nxt = S_IDLE;
            end
            S_SETTLE: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_zero) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_stop) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_zero) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = (w_state_nxt != r_state);
        w_load_val = '0;
        case (w_state_nxt)
            S_DETECT: w_load_val = c_DET_LOAD;
            S_SETTLE: w_load_val = c_SETTLE_LOAD;
            S_DRAIN:  w_load_val = c_DRAIN_LOAD;
            default:  w_load_val = '0;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        w_elec_idle  = 1'b1;
        w_rst_emisor = 1'b1;
        w_enb        = 1'b0;
        w_detect     = 1'b0;
        w_listo      = 1'b0;
        case (w_state_nxt)
            S_DETECT: w_detect = 1'b1;
            S_SETTLE: begin
                w_elec_idle  = 1'b0;
                w_rst_emisor = 1'b0;
            end
            S_ACTIVE: begin
                w_elec_idle  = 1'b0;
                w_rst_emisor = 1'b0;
                w_enb        = 1'b1;
                w_listo      = 1'b1;
            end
            S_DRAIN: begin
                w_elec_idle  = 1'b0;
                w_rst_emisor = 1'b0;
                w_enb        = 1'b1;
            end
            default: ;
        endcase
    end

    contador_ciclos #(
        .CNT_W(CNT_W)
    ) u_contador (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_elec_idle  <= 1'b1;
            r_rst_emisor <= 1'b1;
            r_enb        <= 1'b0;
            r_detect     <= 1'b0;
            r_listo      <= 1'b0;
            r_ocupado    <= 1'b0;
            r_margin     <= 1'b0;
            r_swing      <= 1'b0;
            r_deemph     <= 1'b0;
            r_det_ok     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_elec_idle  <= w_elec_idle;
            r_rst_emisor <= w_rst_emisor;
            r_enb        <= w_enb;
            r_detect     <= w_detect;
            r_listo      <= w_listo;
            r_ocupado    <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE) begin
                r_margin <= cfg_margin;
                r_swing  <= cfg_swing;
                r_deemph <= cfg_deemph;
            end
            if (r_state == S_DETECT && w_zero) begin
                r_det_ok <= rx_presente;
            end
        end
    end

    assign enb_emisor = r_enb;
    assign rst_emisor = r_rst_emisor;
    assign TxElecIdle = r_elec_idle;
    assign TxDetectRx = r_detect;
    assign TxMargin   = r_margin;
    assign TxSwing    = r_swing;
    assign TxDeemph   = r_deemph;
    assign det_ok     = r_det_ok;
    assign listo      = r_listo;
    assign ocupado    = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_controlador_tx_diferencial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_controlador_tx_diferencial                                              |
// | Directed scenarios plus random traffic against a phase/time-left model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_controlador_tx_diferencial;

    localparam int c_DET    = 16;
    localparam int c_SETTLE = 4;
    localparam int c_DRAIN  = 8;

    localparam int PH_IDLE   = 0;
    localparam int PH_DETECT = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_ACTIVE = 3;
    localparam int PH_DRAIN  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic det_req = 0, tx_req = 0, idle_req = 0, rx_presente = 0;
    logic cfg_margin = 0, cfg_swing = 0, cfg_deemph = 0;
    logic enb_emisor, rst_emisor, TxElecIdle, TxDetectRx;
    logic TxMargin, TxSwing, TxDeemph, det_ok, listo, ocupado;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    int m_ph, m_left;
    bit m_det_ok, m_margin, m_swing, m_deemph;

    controlador_tx_diferencial dut (
        .clk        (clk),
        .rst        (rst),
        .det_req    (det_req),
        .tx_req     (tx_req),
        .idle_req   (idle_req),
        .rx_presente(rx_presente),
        .cfg_margin (cfg_margin),
        .cfg_swing  (cfg_swing),
        .cfg_deemph (cfg_deemph),
        .enb_emisor (enb_emisor),
        .rst_emisor (rst_emisor),
        .TxElecIdle (TxElecIdle),
        .TxDetectRx (TxDetectRx),
        .TxMargin   (TxMargin),
        .TxSwing    (TxSwing),
        .TxDeemph   (TxDeemph),
        .det_ok     (det_ok),
        .listo      (listo),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_left = 0; m_det_ok = 0;
        m_margin = 0; m_swing = 0; m_deemph = 0;
    endtask

    // Model: phase plus number of cycles still to spend in it
    task automatic model_step();
        bit stop;
        stop = !tx_req || idle_req;
        case (m_ph)
            PH_IDLE: begin
                m_margin = cfg_margin; m_swing = cfg_swing; m_deemph = cfg_deemph;
                if (det_req) begin
                    m_ph = PH_DETECT; m_left = c_DET;
                end else if (!stop && m_det_ok) begin
                    m_ph = PH_SETTLE; m_left = c_SETTLE;
                end
            end
            PH_DETECT: begin
                m_left--;
                if (m_left == 0) begin
                    m_det_ok = rx_presente; m_ph = PH_IDLE;
                end
            end
            PH_SETTLE: begin
                if (stop) m_ph = PH_IDLE;
                else begin
                    m_left--;
                    if (m_left == 0) m_ph = PH_ACTIVE;
                end
            end
            PH_ACTIVE: begin
                if (stop) begin
                    m_ph = PH_DRAIN; m_left = c_DRAIN;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_ph = PH_IDLE;
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_elecidle", TxElecIdle, int'(m_ph == PH_IDLE || m_ph == PH_DETECT));
                chk("m_rst_emisor", rst_emisor, int'(m_ph == PH_IDLE || m_ph == PH_DETECT));
                chk("m_enb", enb_emisor, int'(m_ph == PH_ACTIVE || m_ph == PH_DRAIN));
                chk("m_detect", TxDetectRx, int'(m_ph == PH_DETECT));
                chk("m_listo", listo, int'(m_ph == PH_ACTIVE));
                chk("m_ocupado", ocupado, int'(m_ph != PH_IDLE));
                chk("m_det_ok", det_ok, int'(m_det_ok));
                chk("m_margin", TxMargin, int'(m_margin));
                chk("m_swing", TxSwing, int'(m_swing));
                chk("m_deemph", TxDeemph, int'(m_deemph));
            end
        end
    end

    initial begin
        int n;
        chk_en = 1;
        cfg_deemph = 1;
        tick();
        chk("rst_elecidle", TxElecIdle, 1);
        chk("rst_rst_emisor", rst_emisor, 1);
        chk("rst_enb", enb_emisor, 0);
        chk("rst_deemph", TxDeemph, 0);
        chk("rst_ocupado", ocupado, 0);
        rst = 1;
        cfg_deemph = 0;
        tick();

        // Detection with receiver present
        det_req = 1; rx_presente = 1;
        tick();
        det_req = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (TxDetectRx) n++;
            tick();
        end
        chk("det_len", n, 16);
        chk("det_found", det_ok, 1);
        chk("det_back_idle", ocupado, 0);

        // Full sequence with config latch
        cfg_swing = 1;
        tick();
        tx_req = 1;
        tick();
        chk("seq_elecidle_fall", TxElecIdle, 0);
        chk("seq_enb_early", enb_emisor, 0);
        cfg_swing = 0;
        tick(); tick(); tick();
        chk("seq_enb_before", enb_emisor, 0);
        tick();
        chk("seq_enb_rise", enb_emisor, 1);
        chk("seq_listo_rise", listo, 1);
        cfg_swing = 1; tick(); cfg_swing = 0; tick();
        chk("seq_swing_frozen", TxSwing, 1);
        tx_req = 0;
        tick();
        chk("seq_listo_fall", listo, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (enb_emisor) n++;
            tick();
        end
        chk("seq_drain_len", n, 8);
        chk("seq_elecidle_back", TxElecIdle, 1);
        chk("seq_swing_relatched", TxSwing, 0);

        // idle_req during SETTLE
        tx_req = 1;
        tick();
        chk("abort_in_settle", ocupado, 1);
        idle_req = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (enb_emisor) n++;
        end
        chk("abort_enb_never", n, 0);
        chk("abort_idle", ocupado, 0);
        tx_req = 0; tick(); idle_req = 0;

        // det_req beats tx_req; this detection finds no receiver
        det_req = 1; tx_req = 1; rx_presente = 0;
        tick();
        chk("simul_detect", TxDetectRx, 1);
        chk("simul_elecidle", TxElecIdle, 1);
        det_req = 0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (enb_emisor || !TxElecIdle) n++;
        end
        chk("absent_det_ok", det_ok, 0);
        chk("absent_never_enb", n, 0);
        tx_req = 0;

        // Reset while ACTIVE
        det_req = 1; rx_presente = 1; tick(); det_req = 0;
        repeat (20) tick();
        tx_req = 1;
        repeat (6) tick();
        chk("midrst_pre_enb", enb_emisor, 1);
        rst = 0;
        #1;
        chk("midrst_enb", enb_emisor, 0);
        chk("midrst_elecidle", TxElecIdle, 1);
        chk("midrst_rst_emisor", rst_emisor, 1);
        chk("midrst_det_ok", det_ok, 0);
        chk("midrst_ocupado", ocupado, 0);
        tick();
        rst = 1; tx_req = 0;
        tick();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            det_req     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) tx_req = ~tx_req;
            idle_req    = ($urandom_range(0, 29) == 0);
            rx_presente = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) cfg_margin = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) cfg_swing  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) cfg_deemph = $urandom_range(0, 1);
            if ($urandom_range(0, 599) == 0) rst = 0;
            else rst = 1;
            tick();
        end
        rst = 1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controlador_tx_diferencial.md
Name: controlador_tx_diferencial

Overview:
Sequencer for the NRZI differential transmitter at the serial end of the PCIe TX path. It owns the emitter's enable and reset. It drives the PIPE-style TX sideband (TxElecIdle, TxDetectRx, TxMargin, TxSwing, TxDeemph) and runs receiver detection. It also sequences electrical-idle exit and entry around traffic requested by the upstream link logic, ahead of paraleloSerial/diferencialEmisor.

Parameters:
DET_CICLOS, 16, cycles TxDetectRx is held high per detection; legal range >=1.
SETTLE_CICLOS, 4, cycles between leaving electrical idle and enabling the emitter; legal range >=1.
DRAIN_CICLOS, 8, cycles the emitter stays enabled after a stop request before electrical idle; legal range >=1.
CNT_W, 8, counter width; must hold the largest *_CICLOS value minus 1.

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
det_req  in  1  request one receiver-detect sequence (level, sampled)
tx_req  in  1  link wants to transmit (level)
idle_req  in  1  force return to electrical idle
rx_presente  in  1  PHY receiver-detect result, valid on last DETECT cycle
cfg_margin  in  1  TxMargin value to apply
cfg_swing  in  1  TxSwing value to apply
cfg_deemph  in  1  TxDeemph value to apply
enb_emisor  out  1  enable to differential emitter
rst_emisor  out  1  active-high reset to differential emitter
TxElecIdle  out  1  electrical idle
TxDetectRx  out  1  receiver detect strobe
TxMargin  out  1  latched margin
TxSwing  out  1  latched swing
TxDeemph  out  1  latched de-emphasis
det_ok  out  1  sticky: last detection found a receiver
listo  out  1  emitter active; serial data is valid to send
ocupado  out  1  FSM not in S_IDLE

Behaviour:
- All outputs are registered. A state transition takes effect in the cycle after its condition is sampled.
- Reset (rst=0, any time, including mid-sequence):
  - FSM goes to S_IDLE and the counter goes to 0.
  - TxElecIdle=1, rst_emisor=1. Every other output is 0 (TxDeemph=0 included).
  - Release is synchronous to clk. The first evaluation happens on the first edge with rst=1.
- Counter:
  - Loads the state's parameter value minus 1 on state entry, then decrements once per cycle.
  - The state exits on the cycle the counter reads 0.
  - Wrap-around is never reached.
- S_IDLE:
  - Outputs: TxElecIdle=1, rst_emisor=1, enb_emisor=0, TxDetectRx=0.
  - cfg_* are copied into TxMargin/TxSwing/TxDeemph every cycle. This is the only state where they change; they are frozen in all other states.
  - Transitions, in priority order:
    - det_req=1 -> S_DETECT.
    - Else tx_req=1 and det_ok=1 -> S_SETTLE.
    - tx_req with det_ok=0 is ignored; the FSM stays in S_IDLE.
- S_DETECT:
  - TxDetectRx=1 for exactly DET_CICLOS cycles; TxElecIdle stays 1.
  - On the last cycle, det_ok <= rx_presente. Then -> S_IDLE.
  - det_req, tx_req and idle_req are ignored. A det_req still high on return starts a new detection.
- S_SETTLE:
  - TxElecIdle=0, rst_emisor=0, enb_emisor=0, for SETTLE_CICLOS cycles, then -> S_ACTIVE.
  - tx_req=0 or idle_req=1 at any cycle -> S_IDLE immediately, without drain.
- S_ACTIVE:
  - enb_emisor=1, listo=1, TxElecIdle=0.
  - tx_req=0 or idle_req=1 -> S_DRAIN. det_req is ignored.
- S_DRAIN:
  - enb_emisor=1, listo=0, for DRAIN_CICLOS cycles, then -> S_IDLE.
  - On that transition TxElecIdle returns to 1 and rst_emisor to 1.
  - tx_req reasserting during drain does not abort it; the FSM re-enters via S_IDLE.
- Simultaneous requests: det_req beats tx_req in S_IDLE. idle_req beats tx_req everywhere.
- det_ok is updated only at the end of S_DETECT and cleared only by reset.
- ocupado=1 in every state except S_IDLE.

Decomposition:
- Shared package (tx_ctrl_pkg):
  - State encoding typedef: S_IDLE, S_DETECT, S_SETTLE, S_ACTIVE, S_DRAIN (3-bit).
  - Default cycle constants.
- One natural sub-module: contador_ciclos. It is a loadable down-counter with a zero flag, parameterised by CNT_W, and is reused for all timed states.
- FSM, sideband registers and config latch stay in the top module.

Test Plan:
- Reset mid-ACTIVE: assert rst=0 while enb_emisor=1 -> same cycle enb_emisor=0, TxElecIdle=1, rst_emisor=1, det_ok=0, ocupado=0.
- Detection found: det_req=1 for 1 cycle, rx_presente=1 on cycle 16 -> TxDetectRx high exactly 16 cycles, then det_ok=1, back in S_IDLE.
- Detection absent, then tx_req=1 -> det_ok=0, TxElecIdle stays 1, enb_emisor never rises over 50 cycles.
- Full sequence with det_ok=1, tx_req=1:
  - TxElecIdle falls 1 cycle later.
  - enb_emisor and listo rise 4 cycles after that.
  - Drop tx_req: listo falls next cycle, enb_emisor stays high 8 cycles, then TxElecIdle=1.
- Config latch: cfg_swing=1 in IDLE, toggle cfg_swing during ACTIVE -> TxSwing stays 1 until the next S_IDLE.
- Simultaneous: det_req=1 and tx_req=1 in IDLE with det_ok=1 -> S_DETECT first. idle_req=1 during S_SETTLE -> S_IDLE with enb_emisor never asserted.
